// File: rtl/uart_msg_rx_pkg.sv
// Shared definitions for the UART message receive path: FSM state
// encodings (also intended for the transmit side) and timer sizing helpers.
package uart_msg_rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [7:0] DEFAULT_TERM_CHAR = 8'h0D;

    // Counter width able to hold 0..limit; never narrower than one bit.
    function automatic int gap_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter. Counts enabled cycles since the last clear and
// saturates at LIMIT; expired stays high while the count sits at LIMIT.
module uart_gap_timer
    import uart_msg_rx_pkg::*;
#(
    parameter int LIMIT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = gap_width(LIMIT);

    logic [W-1:0] cnt;

    // Saturating up-count of idle cycles; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != W'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == W'(LIMIT));

endmodule

// File: rtl/uart_msg_rx.sv
// Assembles fixed-length messages from a byte strobe stream.
// Optional feature: define UART_MSG_RX_TERM_EN to let TERM_CHAR end a
// message early (terminator not stored); otherwise TERM_CHAR is plain data.
// A partial message is dropped after TIMEOUT_CYCLES idle cycles (0 = never).
module uart_msg_rx
    import uart_msg_rx_pkg::*;
#(
    parameter int         MSG_LEN        = 1,
    parameter int         TIMEOUT_CYCLES = 0,
    parameter logic [7:0] TERM_CHAR      = DEFAULT_TERM_CHAR
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rcv,
    input  logic [7:0]           data,
    output logic [8*MSG_LEN-1:0] msg,
    output logic                 msg_valid,
    output logic [7:0]           len,
    output logic                 timeout,
    output logic                 busy
);

`ifdef UART_MSG_RX_TERM_EN
    localparam bit TERM_EN = 1'b1;
`else
    localparam bit TERM_EN = 1'b0;
`endif

    state_t               state;
    logic [7:0]           index;
    logic [8*MSG_LEN-1:0] buffer;
    logic [8*MSG_LEN-1:0] next_buf;
    logic                 last;
    logic                 term_hit;
    logic                 expired;

    assign last     = (index == 8'(MSG_LEN - 1));
    assign term_hit = TERM_EN && (data == TERM_CHAR);
    assign busy     = (state == RECV);

    // Buffer with the incoming byte placed at the current index.
    always_comb begin
        next_buf = buffer;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (index == 8'(i)) begin
                next_buf[8*i +: 8] = data;
            end
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_gap
            logic gap_clr;
            logic gap_en;

            assign gap_clr = (state == IDLE) || rcv;
            assign gap_en  = (state == RECV);

            uart_gap_timer #(.LIMIT(TIMEOUT_CYCLES)) u_gap (
                .clk     (clk),
                .rstn    (rstn),
                .clr     (gap_clr),
                .en      (gap_en),
                .expired (expired)
            );
        end else begin : g_no_gap
            assign expired = 1'b0;
        end
    endgenerate

    // Message assembly FSM. A received byte always beats an expiring gap.
    // The buffer is cleared whenever we return to IDLE, so an early
    // terminator leaves unused positions of msg at zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            index     <= '0;
            buffer    <= '0;
            msg       <= '0;
            len       <= '0;
            msg_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            timeout   <= 1'b0;
            if (rcv) begin
                if (term_hit) begin
                    msg       <= buffer;
                    len       <= index;
                    msg_valid <= 1'b1;
                    index     <= '0;
                    buffer    <= '0;
                    state     <= IDLE;
                end else if (last) begin
                    msg       <= next_buf;
                    len       <= 8'(MSG_LEN);
                    msg_valid <= 1'b1;
                    index     <= '0;
                    buffer    <= '0;
                    state     <= IDLE;
                end else begin
                    buffer    <= next_buf;
                    index     <= index + 8'd1;
                    state     <= RECV;
                end
            end else if ((state == RECV) && expired) begin
                index   <= '0;
                buffer  <= '0;
                state   <= IDLE;
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_msg_rx.sv
// Directed bench for uart_msg_rx using three instances:
//   u_a: MSG_LEN=4, TIMEOUT_CYCLES=100
//   u_b: MSG_LEN=2, no timeout
//   u_c: MSG_LEN=4, TIMEOUT_CYCLES=5
module tb_uart_msg_rx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rcv_a, rcv_b, rcv_c;
    logic [7:0]  data;

    logic [31:0] msg_a, msg_c;
    logic [15:0] msg_b;
    logic        mv_a, mv_b, mv_c;
    logic [7:0]  len_a, len_b, len_c;
    logic        to_a, to_b, to_c;
    logic        busy_a, busy_b, busy_c;

    int vectors = 0;
    int miscompares = 0;

    int mv_cnt_a = 0, to_cnt_a = 0, mv_cnt_c = 0, to_cnt_c = 0;
    int overlap = 0;
    int n_b = 0;
    logic [15:0] cap_b [0:7];

    int mv0, to0;

    always #5 clk = ~clk;

    uart_msg_rx #(.MSG_LEN(4), .TIMEOUT_CYCLES(100)) u_a (
        .clk(clk), .rstn(rstn), .rcv(rcv_a), .data(data),
        .msg(msg_a), .msg_valid(mv_a), .len(len_a), .timeout(to_a), .busy(busy_a)
    );

    uart_msg_rx #(.MSG_LEN(2), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .rstn(rstn), .rcv(rcv_b), .data(data),
        .msg(msg_b), .msg_valid(mv_b), .len(len_b), .timeout(to_b), .busy(busy_b)
    );

    uart_msg_rx #(.MSG_LEN(4), .TIMEOUT_CYCLES(5)) u_c (
        .clk(clk), .rstn(rstn), .rcv(rcv_c), .data(data),
        .msg(msg_c), .msg_valid(mv_c), .len(len_c), .timeout(to_c), .busy(busy_c)
    );

    // Pulse monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (mv_a) mv_cnt_a++;
        if (to_a) to_cnt_a++;
        if (mv_c) mv_cnt_c++;
        if (to_c) to_cnt_c++;
        if ((mv_a && to_a) || (mv_b && to_b) || (mv_c && to_c)) overlap++;
        if (mv_b) begin
            if (n_b < 8) cap_b[n_b] = msg_b;
            n_b++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        data = b; rcv_a = 1'b1; tick(); rcv_a = 1'b0;
    endtask

    task automatic send_c(input logic [7:0] b);
        data = b; rcv_c = 1'b1; tick(); rcv_c = 1'b0;
    endtask

    task automatic send_a_spaced(input logic [7:0] b);
        send_a(b);
        repeat (9) tick();
    endtask

    initial begin
        rstn = 1'b0; rcv_a = 1'b0; rcv_b = 1'b0; rcv_c = 1'b0; data = 8'h00;
        tick(); tick();

        // Reset values
        chk("rst_msg",   msg_a, 0);
        chk("rst_len",   len_a, 0);
        chk("rst_mv",    mv_a,  0);
        chk("rst_to",    to_a,  0);
        chk("rst_busy",  busy_a, 0);
        chk("rst_msg_b", msg_b, 0);
        rstn = 1'b1;
        tick();

        // HOLA spaced 10 cycles
        mv0 = mv_cnt_a;
        send_a_spaced(8'h48);
        send_a_spaced(8'h4F);
        send_a_spaced(8'h4C);
        chk("hola_busy", busy_a, 1);
        chk("hola_no_mv", mv_a, 0);
        send_a(8'h41);
        chk("hola_mv", mv_a, 1);
        chk("hola_msg", msg_a, 32'h414C4F48);
        chk("hola_len", len_a, 4);
        chk("hola_idle", busy_a, 0);
        tick();
        chk("hola_mv_end", mv_a, 0);
        tick();
        chk("hola_pulses", mv_cnt_a - mv0, 1);

        // Partial message then timeout, then HOLA
        mv0 = mv_cnt_a; to0 = to_cnt_a;
        send_a(8'h11);
        send_a(8'h22);
        repeat (100) tick();
        chk("to_not_yet", to_a, 0);
        chk("to_busy_hold", busy_a, 1);
        tick();
        chk("to_pulse", to_a, 1);
        chk("to_idle", busy_a, 0);
        chk("to_msg_kept", msg_a, 32'h414C4F48);
        tick();
        chk("to_pulse_end", to_a, 0);
        send_a_spaced(8'h48);
        send_a_spaced(8'h4F);
        send_a_spaced(8'h4C);
        send_a(8'h41);
        chk("to_hola_msg", msg_a, 32'h414C4F48);
        tick();
        chk("to_pulses", to_cnt_a - to0, 1);
        chk("to_mv_pulses", mv_cnt_a - mv0, 1);

        // O, K, CR
        mv0 = mv_cnt_a;
        send_a(8'h4F);
        send_a(8'h4B);
        send_a(8'h0D);
`ifdef UART_MSG_RX_TERM_EN
        chk("term_mv", mv_a, 1);
        chk("term_msg", msg_a, 32'h00004B4F);
        chk("term_len", len_a, 2);
        chk("term_idle", busy_a, 0);
        send_a(8'h0D);
        chk("term_idle_mv", mv_a, 1);
        chk("term_idle_len", len_a, 0);
        chk("term_idle_msg", msg_a, 0);
        tick();
        chk("term_pulses", mv_cnt_a - mv0, 2);
`else
        chk("cr_no_mv", mv_a, 0);
        chk("cr_busy", busy_a, 1);
        tick();
        chk("cr_no_pulse", mv_cnt_a - mv0, 0);
        send_a(8'h21);
        chk("cr_mv", mv_a, 1);
        chk("cr_msg", msg_a, 32'h210D4B4F);
        chk("cr_len", len_a, 4);
        tick();
`endif

        // Reset mid-message, rcv held during reset
        send_a(8'h01);
        send_a(8'h02);
        send_a(8'h03);
        chk("mid_busy", busy_a, 1);
        mv0 = mv_cnt_a; to0 = to_cnt_a;
        rstn = 1'b0; data = 8'h55; rcv_a = 1'b1;
        tick();
        rstn = 1'b1; rcv_a = 1'b0;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_msg", msg_a, 0);
        chk("mid_rst_len", len_a, 0);
        tick(); tick();
        chk("mid_rst_no_mv", mv_cnt_a - mv0, 0);
        chk("mid_rst_no_to", to_cnt_a - to0, 0);
        send_a(8'hA1);
        send_a(8'hB2);
        send_a(8'hC3);
        chk("post_rst_busy", busy_a, 1);
        send_a(8'hD4);
        chk("post_rst_mv", mv_a, 1);
        chk("post_rst_msg", msg_a, 32'hD4C3B2A1);
        chk("post_rst_len", len_a, 4);
        tick();

        // Back-to-back bytes into the 2-byte instance
        n_b = 0;
        rcv_b = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            data = 8'(i);
            tick();
        end
        rcv_b = 1'b0;
        tick(); tick();
        chk("b2b_count", n_b, 3);
        chk("b2b_msg0", cap_b[0], 16'h0201);
        chk("b2b_msg1", cap_b[1], 16'h0403);
        chk("b2b_msg2", cap_b[2], 16'h0605);
        chk("b2b_len", len_b, 2);
        chk("b2b_idle", busy_b, 0);

        // Byte arriving in the expiry cycle, then a real expiry
        to0 = to_cnt_c;
        send_c(8'h31);
        repeat (5) tick();
        send_c(8'h32);
        chk("exp_rcv_no_to", to_c, 0);
        chk("exp_rcv_busy", busy_c, 1);
        repeat (5) tick();
        chk("exp2_not_yet", to_c, 0);
        tick();
        chk("exp2_to", to_c, 1);
        chk("exp2_idle", busy_c, 0);
        chk("exp2_msg_kept", msg_c, 0);
        tick(); tick();
        chk("exp_to_pulses", to_cnt_c - to0, 1);
        chk("exp_no_mv", mv_cnt_c, 0);

        chk("no_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
